// File: rtl/mac_vector_engine.sv
// Dot-product engine: loadable data/coef RAMs and a paced multiply-accumulate sequence
// that leaves the full sum, a saturated copy and a clip flag on the output.
module mac_vector_engine #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int ACC_W    = 2*DATA_W+ADDR_W+1,
  parameter int PACE_DIV = 0,
  parameter int SIGNED   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              wr_sel,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W:0]   len,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result,
  output logic [DATA_W-1:0] result_sat,
  output logic              sat
);

  localparam int PACE_W = $clog2(PACE_DIV+2);
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((1 << (DATA_W-1)) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = -SMAX - 1;
  localparam logic [ACC_W-1:0]        UMAX = ACC_W'((1 << DATA_W) - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_MAC, S_WAIT, S_DONE} state_t;

  state_t              state;
  logic [DATA_W-1:0]   data_ram [DEPTH];
  logic [DATA_W-1:0]   coef_ram [DEPTH];
  logic [DATA_W-1:0]   data_p1, coef_p1;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W:0]     len_q, len_c;
  logic [ACC_W-1:0]    acc, prod_ext, acc_nxt;
  logic [PACE_W-1:0]   pace_cnt;
  logic signed [2*DATA_W-1:0] prod_s;
  logic [2*DATA_W-1:0] prod_u;
  logic                idle_like, wr_ok, last;

  // Returns {clipped, value} for the DATA_W-wide readout.
  function automatic logic [DATA_W:0] saturate(input logic [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] sv;
    sv = $signed(v);
    if (SIGNED != 0) begin
      if (sv > SMAX) return {1'b1, SMAX[DATA_W-1:0]};
      if (sv < SMIN) return {1'b1, SMIN[DATA_W-1:0]};
    end else if (v > UMAX) begin
      return {1'b1, UMAX[DATA_W-1:0]};
    end
    return {1'b0, v[DATA_W-1:0]};
  endfunction

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign wr_ok     = wr_en && idle_like;
  assign len_c     = (len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : len;
  assign last      = ({1'b0, idx} == (len_q - 1'b1));

  // Stage p0 -> p1: synchronous RAM read at idx, valid in the MAC cycle
  always_ff @(posedge clk) begin
    if (wr_ok && !wr_sel) data_ram[wr_addr] <= wr_data;
    if (wr_ok &&  wr_sel) coef_ram[wr_addr] <= wr_data;
    data_p1 <= data_ram[idx];
    coef_p1 <= coef_ram[idx];
  end

  always_comb begin
    prod_s = $signed(data_p1) * $signed(coef_p1);
    prod_u = data_p1 * coef_p1;
    if (SIGNED != 0) prod_ext = ACC_W'(prod_s);
    else             prod_ext = ACC_W'(prod_u);
    acc_nxt = acc + prod_ext;
  end

  // Stage p1 -> acc: control FSM and accumulate
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      result_sat <= '0;
      sat        <= 1'b0;
      acc        <= '0;
      idx        <= '0;
      len_q      <= '0;
      pace_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            acc   <= '0;
            idx   <= '0;
            len_q <= len_c;
            if (len_c == '0) begin
              state      <= S_DONE;
              done       <= 1'b1;
              result     <= '0;
              result_sat <= '0;
              sat        <= 1'b0;
            end else begin
              state <= S_FETCH;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        S_FETCH: state <= S_MAC;
        S_MAC: begin
          acc <= acc_nxt;
          idx <= idx + 1'b1;
          if (last) begin
            state              <= S_DONE;
            busy               <= 1'b0;
            done               <= 1'b1;
            result             <= acc_nxt;
            {sat, result_sat}  <= saturate(acc_nxt);
          end else if (PACE_DIV > 0) begin
            state    <= S_WAIT;
            pace_cnt <= PACE_W'(1);
          end else begin
            state <= S_FETCH;
          end
        end
        S_WAIT: begin
          if (pace_cnt == PACE_W'(PACE_DIV)) state <= S_FETCH;
          else                               pace_cnt <= pace_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
